// File: rtl/credit_tx_if.sv
// Producer-side handshake and credit-link signals of the credit transmitter.
// The slave modport is the transmitter; the master modport drives it.
interface credit_tx_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CW         = 8
);
    logic [DATA_WIDTH:0] src_data;
    logic                src_valid;
    logic                src_ready;
    logic                enq_out;
    logic [DATA_WIDTH:0] d_out;
    logic                credit_in;
    logic [CW-1:0]       credits;
    logic                idle;
    logic                err_ovf;

    modport master (
        output src_data,
        output src_valid,
        output credit_in,
        input  src_ready,
        input  enq_out,
        input  d_out,
        input  credits,
        input  idle,
        input  err_ovf
    );

    modport slave (
        input  src_data,
        input  src_valid,
        input  credit_in,
        output src_ready,
        output enq_out,
        output d_out,
        output credits,
        output idle,
        output err_ovf
    );
endinterface

// File: rtl/credit_tx.sv
// Credit-based link transmitter: 2-entry holding queue feeding a registered
// enq pulse, gated by a credit counter refilled by receiver credit returns.
module credit_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 4,
    parameter int CW         = 8
) (
    input logic        clk,
    input logic        rst_n,
    credit_tx_if.slave link
);
    localparam int            W    = DATA_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(CREDITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        DRAINED = 2'd0,
        PARTIAL = 2'd1,
        STALLED = 2'd2
    } cstate_t;

    logic [W-1:0]  mem [2];
    logic          wp;
    logic          rp;
    logic [1:0]    cnt;
    logic [1:0]    cnt_d;
    logic          live;
    logic [CW-1:0] credits_q;
    logic [CW-1:0] credits_d;
    logic          enq_q;
    logic [W-1:0]  dout_q;
    logic          err_q;
    cstate_t       cs_q;
    cstate_t       cs_d;

    logic ready;
    logic send;
    logic acc;
    logic ovf;
    logic cin;

    // live keeps src_ready low for the first edge after reset release
    assign ready = live && (cnt != 2'd2);
    assign cin   = link.credit_in;

    always_comb begin
        send = (cnt != 2'd0) && (credits_q != '0);
        acc  = link.src_valid && ready;
        ovf  = cin && !send && (credits_q == FULL);
    end

    always_comb begin
        credits_d = credits_q;
        unique case (1'b1)
            send && !cin:                      credits_d = credits_q - ONE;
            !send && cin && credits_q != FULL: credits_d = credits_q + ONE;
            default:                           credits_d = credits_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt;
        unique case (1'b1)
            acc && !send: cnt_d = cnt + 2'd1;
            send && !acc: cnt_d = cnt - 2'd1;
            default:      cnt_d = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            cnt       <= 2'd0;
            live      <= 1'b0;
            credits_q <= FULL;
            enq_q     <= 1'b0;
            dout_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            live      <= 1'b1;
            cnt       <= cnt_d;
            credits_q <= credits_d;
            if (acc) begin
                mem[wp] <= link.src_data;
                wp      <= ~wp;
            end
            if (send) begin
                enq_q  <= 1'b1;
                dout_q <= mem[rp];
                rp     <= ~rp;
            end else begin
                enq_q  <= 1'b0;
            end
            if (ovf) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q <= DRAINED;
        end else begin
            cs_q <= cs_d;
        end
    end

    always_comb begin
        cs_d = cs_q;
        unique case (1'b1)
            credits_d == FULL: cs_d = DRAINED;
            credits_d == '0:   cs_d = STALLED;
            default:           cs_d = PARTIAL;
        endcase
    end

    assign link.src_ready = ready;
    assign link.enq_out   = enq_q;
    assign link.d_out     = dout_q;
    assign link.credits   = credits_q;
    assign link.err_ovf   = err_q;
    assign link.idle      = live && (cs_q == DRAINED)
                          && (cnt == 2'd0) && !enq_q;
endmodule

// File: tb/tb_credit_tx.sv
// Directed + randomized bench for credit_tx against a queue-based model
// of the credit link (holding queue, credit count, sticky overflow).
module tb_credit_tx;
    localparam int DW      = 64;
    localparam int CREDITS = 4;
    localparam int CW      = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    credit_tx_if #(.DATA_WIDTH(DW), .CW(CW)) bus ();

    credit_tx #(
        .DATA_WIDTH(DW),
        .CREDITS   (CREDITS),
        .CW        (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .link (bus)
    );

    int vectors = 0;
    int errs    = 0;

    logic [DW:0] mq [$];
    int          m_cred;
    bit          m_enq;
    logic [DW:0] m_dout;
    bit          m_err;
    bit          m_live;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cred = CREDITS;
        m_enq  = 1'b0;
        m_dout = '0;
        m_err  = 1'b0;
        m_live = 1'b0;
    endtask

    task automatic check_all(input string ph);
        bit m_idle;
        bit m_rdy;
        m_rdy  = m_live && (mq.size() < 2);
        m_idle = m_live && (m_cred == CREDITS) && (mq.size() == 0) && !m_enq;
        chk({ph, ".enq"}, 128'(bus.enq_out), 128'(m_enq));
        chk({ph, ".dout"}, 128'(bus.d_out), 128'(m_dout));
        chk({ph, ".cred"}, 128'(bus.credits), 128'(m_cred));
        chk({ph, ".rdy"}, 128'(bus.src_ready), 128'(m_rdy));
        chk({ph, ".idle"}, 128'(bus.idle), 128'(m_idle));
        chk({ph, ".err"}, 128'(bus.err_ovf), 128'(m_err));
    endtask

    // One clock: drive inputs, advance model by the link rules, compare.
    task automatic cyc(input string ph, input bit v, input logic [DW:0] d,
                       input bit c, output bit a);
        bit s;
        bus.src_valid = v;
        bus.src_data  = d;
        bus.credit_in = c;
        s = (mq.size() != 0) && (m_cred != 0);
        a = v && m_live && (mq.size() < 2);
        @(posedge clk);
        #1;
        if (s) begin
            m_enq  = 1'b1;
            m_dout = mq.pop_front();
        end else begin
            m_enq = 1'b0;
        end
        if (a) mq.push_back(d);
        if (c && !s && m_cred == CREDITS) m_err = 1'b1;
        else m_cred = m_cred - int'(s) + int'(c);
        m_live = 1'b1;
        check_all(ph);
        bus.src_valid = 1'b0;
        bus.credit_in = 1'b0;
    endtask

    function automatic logic [DW:0] rword();
        logic [DW:0] w;
        w = {1'($urandom), $urandom, $urandom};
        return w;
    endfunction

    task automatic refill(input string ph);
        bit a;
        for (int i = 0; i < 20; i++) begin
            if (m_cred == CREDITS && mq.size() == 0 && !m_enq) break;
            cyc(ph, 1'b0, '0, m_cred < CREDITS, a);
        end
        chk({ph, ".idle_reached"}, 128'(bus.idle), 128'(1));
    endtask

    initial begin
        bit          a;
        int          idx;
        logic [DW:0] w;
        logic [DW:0] burst [6];

        rst_n         = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.credit_in = 1'b0;
        model_reset();

        repeat (3) begin
            @(posedge clk);
            #1;
            check_all("rst");
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rel", 1'b0, '0, 1'b0, a);
        chk("rel.idle1", 128'(bus.idle), 128'(1));
        chk("rel.rdy1", 128'(bus.src_ready), 128'(1));

        for (int i = 0; i < 6; i++) burst[i] = 65'(32'h10 + i);
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            if (idx < 6) begin
                cyc("burst", 1'b1, burst[idx], 1'b0, a);
                if (a) idx++;
            end else begin
                cyc("burst", 1'b0, '0, 1'b0, a);
            end
        end
        chk("burst.cred0", 128'(bus.credits), 128'(0));
        chk("burst.rdy0", 128'(bus.src_ready), 128'(0));
        chk("burst.qlen", 128'(mq.size()), 128'(2));

        cyc("cret", 1'b0, '0, 1'b1, a);
        chk("cret.noenq", 128'(bus.enq_out), 128'(0));
        cyc("cret", 1'b0, '0, 1'b0, a);
        chk("cret.enq", 128'(bus.enq_out), 128'(1));
        chk("cret.d14", 128'(bus.d_out), 128'(65'h14));
        chk("cret.cred0", 128'(bus.credits), 128'(0));
        chk("cret.rdy", 128'(bus.src_ready), 128'(1));
        cyc("cret", 1'b0, '0, 1'b0, a);
        chk("cret.once", 128'(bus.enq_out), 128'(0));

        refill("fill1");
        cyc("two", 1'b1, rword(), 1'b0, a);
        cyc("two", 1'b1, rword(), 1'b0, a);
        cyc("two", 1'b0, '0, 1'b0, a);
        chk("two.cred2", 128'(bus.credits), 128'(2));

        for (int i = 0; i < 12; i++) begin
            cyc("simul", 1'b1, rword(), i > 0, a);
            if (i > 1) begin
                chk("simul.enq", 128'(bus.enq_out), 128'(1));
                chk("simul.cred2", 128'(bus.credits), 128'(2));
            end
        end
        cyc("simul", 1'b0, '0, 1'b1, a);
        chk("simul.end", 128'(bus.credits), 128'(2));

        refill("fill2");
        cyc("ovf", 1'b0, '0, 1'b1, a);
        chk("ovf.err", 128'(bus.err_ovf), 128'(1));
        chk("ovf.cred", 128'(bus.credits), 128'(CREDITS));

        for (int i = 0; i < 300; i++) begin
            cyc("rand", 1'($urandom), rword(), ($urandom % 3) == 0, a);
        end
        chk("rand.sticky", 128'(bus.err_ovf), 128'(1));

        refill("fill3");
        for (int i = 0; i < 20; i++) begin
            if (m_cred == 0 && mq.size() == 2) break;
            cyc("pre", 1'b1, rword(), 1'b0, a);
        end
        cyc("pre", 1'b0, '0, 1'b1, a);
        chk("pre.cred1", 128'(bus.credits), 128'(1));
        chk("pre.q2", 128'(bus.src_ready), 128'(0));

        rst_n = 1'b0;
        #1;
        chk("mrst.enq", 128'(bus.enq_out), 128'(0));
        chk("mrst.cred", 128'(bus.credits), 128'(CREDITS));
        chk("mrst.err", 128'(bus.err_ovf), 128'(0));
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all("mrst");
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post", 1'b0, '0, 1'b0, a);
        cyc("post", 1'b0, '0, 1'b0, a);
        w = rword();
        cyc("post", 1'b1, w, 1'b0, a);
        chk("post.acc", 128'(a), 128'(1));
        cyc("post", 1'b0, '0, 1'b0, a);
        chk("post.first", 128'(bus.d_out), 128'(w));
        chk("post.enq", 128'(bus.enq_out), 128'(1));
        for (int i = 0; i < 4; i++) begin
            cyc("post", 1'b0, '0, 1'b0, a);
            chk("post.nostale", 128'(bus.enq_out), 128'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
